cic_rate_sequencer: RTL and testbench

CIC_RATE_SEQUENCER -- requirements
Module: cic_rate_sequencer

---
 rtl/cic_seq_pkg.sv | 20 ++
 rtl/cic_rate_sequencer.sv | 142 ++++++++++++++
 tb/tb_cic_rate_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cic_seq_pkg.sv
// Shared state encoding and default parameter constants for the CIC rate sequencer.
package cic_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_DRAIN  = 3'd4
  } seq_state_e;

  localparam int DEF_STREAM_W     = 32;
  localparam int DEF_RATE_W       = 16;
  localparam int DEF_RATE_MIN     = 2;
  localparam int DEF_RATE_MAX     = 4096;
  localparam int DEF_RATE_DEFAULT = 16;
  localparam int DEF_SETTLE_N     = 4;
  localparam int SETTLE_CNT_W     = 8;

endpackage

// File: rtl/cic_rate_sequencer.sv
// Sequences CIC decimation-rate changes: clear, discard settling outputs, run, drain.
// Optional irq_o output is enabled by defining CIC_RATE_SEQUENCER_IRQ_EN.
module cic_rate_sequencer
  import cic_seq_pkg::*;
#(
  parameter int STREAM_W     = DEF_STREAM_W,
  parameter int RATE_W       = DEF_RATE_W,
  parameter int RATE_MIN     = DEF_RATE_MIN,
  parameter int RATE_MAX     = DEF_RATE_MAX,
  parameter int RATE_DEFAULT = DEF_RATE_DEFAULT,
  parameter int SETTLE_N     = DEF_SETTLE_N
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    enable_i,
  input  logic                    req_valid_i,
  input  logic [RATE_W-1:0]       req_rate_i,
  output logic                    req_ready_o,
  input  logic                    err_clr_i,
  output logic                    err_o,
  output logic [RATE_W-1:0]       cic_rate_o,
  output logic                    cic_clear_o,
  output logic                    cic_en_o,
  input  logic [STREAM_W-1:0]     tdata_s_in,
  input  logic                    tvalid_s_in,
  output logic                    tready_s_in,
  output logic [STREAM_W-1:0]     tdata_m_out,
  output logic                    tvalid_m_out,
  input  logic                    tready_m_out,
  output logic [2:0]              state_o,
  output logic [SETTLE_CNT_W-1:0] settle_cnt_o
`ifdef CIC_RATE_SEQUENCER_IRQ_EN
  , output logic                  irq_o
`endif
);

  seq_state_e              state_q, state_d;
  logic                    pending_valid_q;
  logic [RATE_W-1:0]       pending_rate_q;
  logic [RATE_W-1:0]       cic_rate_q;
  logic                    err_q;
  logic [SETTLE_CNT_W-1:0] settle_cnt_q, settle_cnt_d;

  logic req_fire;
  logic req_legal;
  logic err_set;

  // Illegal requests are still consumed so the requester never deadlocks.
  assign req_fire  = ce && req_valid_i && !pending_valid_q;
  assign req_legal = (req_rate_i >= RATE_W'(RATE_MIN)) && (req_rate_i <= RATE_W'(RATE_MAX));
  assign err_set   = req_fire && !req_legal;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    unique case (state_q)
      ST_IDLE: if (enable_i) state_d = ST_CLEAR;
      ST_CLEAR: begin
        settle_cnt_d = '0;
        state_d      = enable_i ? ST_SETTLE : ST_IDLE;
      end
      ST_SETTLE: begin
        if (!enable_i) begin
          state_d      = ST_IDLE;
          settle_cnt_d = '0;
        end else if (tvalid_s_in) begin
          settle_cnt_d = settle_cnt_q + 1'b1;
          if (settle_cnt_q + 1'b1 == SETTLE_CNT_W'(SETTLE_N)) state_d = ST_RUN;
        end
      end
      ST_RUN: if (pending_valid_q || !enable_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        settle_cnt_d = '0;
        if (!(tvalid_s_in && !tready_m_out)) state_d = enable_i ? ST_CLEAR : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stream steering depends only on the current state so it stays correct while ce=0.
  always_comb begin
    cic_en_o     = 1'b0;
    tready_s_in  = 1'b0;
    tvalid_m_out = 1'b0;
    unique case (state_q)
      ST_SETTLE: begin
        cic_en_o    = 1'b1;
        tready_s_in = 1'b1;
      end
      ST_RUN: begin
        cic_en_o     = 1'b1;
        tready_s_in  = tready_m_out;
        tvalid_m_out = tvalid_s_in;
      end
      ST_DRAIN: begin
        tready_s_in  = tready_m_out;
        tvalid_m_out = tvalid_s_in;
      end
      default: ;
    endcase
  end

  // NOTE: reset is sampled on the clock edge, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      pending_valid_q <= 1'b0;
      pending_rate_q  <= '0;
      cic_rate_q      <= RATE_W'(RATE_DEFAULT);
      err_q           <= 1'b0;
      settle_cnt_q    <= '0;
    end else if (ce) begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      // Consume and accept are exclusive: accept needs the slot empty, consume needs it full.
      if (state_q == ST_CLEAR && pending_valid_q) begin
        cic_rate_q      <= pending_rate_q;
        pending_valid_q <= 1'b0;
      end else if (req_fire && req_legal) begin
        pending_valid_q <= 1'b1;
        pending_rate_q  <= req_rate_i;
      end
      if (err_set)        err_q <= 1'b1;
      else if (err_clr_i) err_q <= 1'b0;
    end
  end

  assign req_ready_o  = !pending_valid_q;
  assign err_o        = err_q;
  assign cic_rate_o   = cic_rate_q;
  assign cic_clear_o  = ce && (state_q == ST_CLEAR);
  assign tdata_m_out  = tdata_s_in;
  assign state_o      = state_q;
  assign settle_cnt_o = settle_cnt_q;

`ifdef CIC_RATE_SEQUENCER_IRQ_EN
  assign irq_o = ce && ((state_q == ST_SETTLE && state_d == ST_RUN) || (err_set && !err_q));
`endif

endmodule

// File: tb/tb_cic_rate_sequencer.sv
// Directed and randomized bench for cic_rate_sequencer with a rate/beat reference model.
module tb_cic_rate_sequencer;

  localparam int STREAM_W     = 32;
  localparam int RATE_W       = 16;
  localparam int RATE_MIN     = 2;
  localparam int RATE_MAX     = 4096;
  localparam int RATE_DEFAULT = 16;
  localparam int SETTLE_N     = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  logic                clk = 1'b0;
  logic                reset, ce, enable_i;
  logic                req_valid_i, req_ready_o;
  logic [RATE_W-1:0]   req_rate_i;
  logic                err_clr_i, err_o;
  logic [RATE_W-1:0]   cic_rate_o;
  logic                cic_clear_o, cic_en_o;
  logic [STREAM_W-1:0] tdata_s_in, tdata_m_out;
  logic                tvalid_s_in, tready_s_in, tvalid_m_out, tready_m_out;
  logic [2:0]          state_o;
  logic [7:0]          settle_cnt_o;
`ifdef CIC_RATE_SEQUENCER_IRQ_EN
  logic                irq_o;
`endif

  cic_rate_sequencer #(
    .STREAM_W(STREAM_W), .RATE_W(RATE_W), .RATE_MIN(RATE_MIN), .RATE_MAX(RATE_MAX),
    .RATE_DEFAULT(RATE_DEFAULT), .SETTLE_N(SETTLE_N)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ce           (ce),
    .enable_i     (enable_i),
    .req_valid_i  (req_valid_i),
    .req_rate_i   (req_rate_i),
    .req_ready_o  (req_ready_o),
    .err_clr_i    (err_clr_i),
    .err_o        (err_o),
    .cic_rate_o   (cic_rate_o),
    .cic_clear_o  (cic_clear_o),
    .cic_en_o     (cic_en_o),
    .tdata_s_in   (tdata_s_in),
    .tvalid_s_in  (tvalid_s_in),
    .tready_s_in  (tready_s_in),
    .tdata_m_out  (tdata_m_out),
    .tvalid_m_out (tvalid_m_out),
    .tready_m_out (tready_m_out),
    .state_o      (state_o),
    .settle_cnt_o (settle_cnt_o)
`ifdef CIC_RATE_SEQUENCER_IRQ_EN
    , .irq_o      (irq_o)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int model_rate;
  int model_beats;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_for_state(input logic [2:0] st, input int budget, input string tag);
    int n = 0;
    settle();
    while (state_o !== st && n < budget) begin
      tick();
      n++;
    end
    check(tag, state_o, st);
  endtask

  // One input beat; the model passes it downstream only once SETTLE_N beats were discarded.
  task automatic send_beat(input string tag);
    logic [STREAM_W-1:0] d;
    logic                pass;
    d           = $urandom;
    pass        = (model_beats >= SETTLE_N);
    tdata_s_in  = d;
    tvalid_s_in = 1'b1;
    settle();
    check({tag, "_valid"}, tvalid_m_out, pass);
    if (pass) check({tag, "_data"}, tdata_m_out, d);
    model_beats++;
    tick();
    tvalid_s_in = 1'b0;
  endtask

  // Starts mid-cycle in CLEAR, ends mid-cycle in RUN.
  task automatic clear_and_settle(input int exp_rate, input string tag);
    check({tag, "_clear"}, cic_clear_o, 1'b1);
    tick();
    check({tag, "_rate"}, cic_rate_o, exp_rate);
    check({tag, "_settle"}, state_o, S_SETTLE);
    model_beats = 0;
    for (int i = 0; i < SETTLE_N; i++) send_beat({tag, "_beat"});
    check({tag, "_run"}, state_o, S_RUN);
  endtask

  task automatic check_reset_values(input string tag);
    settle();
    check({tag, "_state"}, state_o, S_IDLE);
    check({tag, "_rate"}, cic_rate_o, RATE_DEFAULT);
    check({tag, "_clear"}, cic_clear_o, 1'b0);
    check({tag, "_en"}, cic_en_o, 1'b0);
    check({tag, "_ready"}, req_ready_o, 1'b1);
    check({tag, "_err"}, err_o, 1'b0);
    check({tag, "_cnt"}, settle_cnt_o, 8'd0);
    check({tag, "_tvalid_m"}, tvalid_m_out, 1'b0);
    check({tag, "_tready_s"}, tready_s_in, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RATE_W-1:0]   r;
    logic [STREAM_W-1:0] d;
    int                  kind;
    bit                  legal;

    reset = 1'b1; ce = 1'b1; enable_i = 1'b0;
    req_valid_i = 1'b0; req_rate_i = '0; err_clr_i = 1'b0;
    tdata_s_in = '0; tvalid_s_in = 1'b0; tready_m_out = 1'b1;
    model_rate = RATE_DEFAULT;
    model_beats = 0;
    repeat (3) tick();
    check_reset_values("reset");
    reset = 1'b0;

    // Startup: clear pulse, first SETTLE_N beats dropped, later beats pass through.
    enable_i = 1'b1;
    tick();
    check("start_state_clear", state_o, S_CLEAR);
    check("start_clear_pulse", cic_clear_o, 1'b1);
    check("start_rate", cic_rate_o, RATE_DEFAULT);
    tick();
    check("start_en", cic_en_o, 1'b1);
    check("start_tready_s", tready_s_in, 1'b1);
    check("start_tvalid_m", tvalid_m_out, 1'b0);
    model_beats = 0;
    for (int i = 0; i < 6; i++) begin
      send_beat("start_beat");
      if (i == 1) check("start_cnt2", settle_cnt_o, 8'd2);
    end
    check("start_run", state_o, S_RUN);

    // Zero-latency passthrough with random handshakes.
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      tdata_s_in   = d;
      tvalid_s_in  = 1'($urandom_range(0, 1));
      tready_m_out = 1'($urandom_range(0, 1));
      settle();
      check("pass_tvalid", tvalid_m_out, tvalid_s_in);
      check("pass_tready", tready_s_in, tready_m_out);
      check("pass_tdata", tdata_m_out, d);
      tick();
    end
    tvalid_s_in = 1'b0; tready_m_out = 1'b1;

    // Rate change with a stalled downstream beat: DRAIN holds until the beat leaves.
    tvalid_s_in = 1'b1; tdata_s_in = $urandom; tready_m_out = 1'b0;
    req_valid_i = 1'b1; req_rate_i = 16'd64;
    settle();
    check("stall_ready_before", req_ready_o, 1'b1);
    tick();
    req_valid_i = 1'b0;
    check("stall_ready_after", req_ready_o, 1'b0);
    check("stall_still_run", state_o, S_RUN);
    tick();
    check("stall_drain", state_o, S_DRAIN);
    check("stall_drain_en", cic_en_o, 1'b0);
    check("stall_drain_tvalid", tvalid_m_out, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_drain", state_o, S_DRAIN);
    end
    tready_m_out = 1'b1;
    tick();
    tvalid_s_in = 1'b0;
    check("stall_to_clear", state_o, S_CLEAR);
    model_rate = 64;
    clear_and_settle(model_rate, "stall");

    // Illegal rates: error flag, no rate change, clear, set-beats-clear, ce freeze.
    req_valid_i = 1'b1; req_rate_i = 16'd1;
    tick();
    req_valid_i = 1'b0;
    check("err_set", err_o, 1'b1);
    check("err_dropped_ready", req_ready_o, 1'b1);
    check("err_rate_kept", cic_rate_o, model_rate);
    check("err_stay_run", state_o, S_RUN);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("err_cleared", err_o, 1'b0);
    req_valid_i = 1'b1; req_rate_i = 16'(RATE_MAX + 1);
    tick();
    req_valid_i = 1'b0;
    check("err_above_max", err_o, 1'b1);
    ce = 1'b0; err_clr_i = 1'b1;
    tick();
    check("ce_freeze_err", err_o, 1'b1);
    ce = 1'b1; req_valid_i = 1'b1; req_rate_i = 16'd0;
    tick();
    req_valid_i = 1'b0;
    check("err_set_wins", err_o, 1'b1);
    tick();
    err_clr_i = 1'b0;
    check("err_cleared2", err_o, 0);

    // Randomized rate requests, including both legal boundaries.
    for (int it = 0; it < 8; it++) begin
      kind = (it < 2) ? it : int'($urandom_range(0, 3));
      case (kind)
        0: r = 16'(RATE_MIN);
        1: r = 16'(RATE_MAX);
        2: r = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, RATE_MIN - 1))
                                            : 16'($urandom_range(RATE_MAX + 1, 65535));
        default: r = 16'($urandom_range(RATE_MIN, RATE_MAX));
      endcase
      legal = (int'(r) >= RATE_MIN) && (int'(r) <= RATE_MAX);
      req_valid_i = 1'b1; req_rate_i = r;
      tick();
      req_valid_i = 1'b0;
      if (!legal) begin
        check("rnd_err", err_o, 1'b1);
        check("rnd_err_rate", cic_rate_o, model_rate);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
      end else begin
        model_rate = int'(r);
        wait_for_state(S_CLEAR, 10, "rnd_wait_clear");
        clear_and_settle(model_rate, "rnd");
      end
    end

    // Back-to-back requests; ce=0 inside CLEAR suppresses the pulse.
    req_valid_i = 1'b1; req_rate_i = 16'd32;
    tick();
    req_rate_i = 16'd128;
    check("b2b_ready_low", req_ready_o, 1'b0);
    for (int n = 0; n < 10 && state_o !== S_CLEAR; n++) begin
      check("b2b_ready_held", req_ready_o, 1'b0);
      tick();
    end
    check("b2b_clear", state_o, S_CLEAR);
    check("b2b_clear_ready", req_ready_o, 1'b0);
    ce = 1'b0;
    settle();
    check("ce_clear_gated", cic_clear_o, 1'b0);
    tick();
    check("ce_state_hold", state_o, S_CLEAR);
    ce = 1'b1;
    settle();
    check("b2b_clear_pulse", cic_clear_o, 1'b1);
    tick();
    check("b2b_rate32", cic_rate_o, 32);
    check("b2b_ready_again", req_ready_o, 1'b1);
    tick();
    req_valid_i = 1'b0;
    check("b2b_second_taken", req_ready_o, 1'b0);
    model_beats = 0;
    for (int i = 0; i < SETTLE_N; i++) send_beat("b2b_beat");
    check("b2b_run", state_o, S_RUN);
    tick();
    check("b2b_run_one_cycle", state_o, S_DRAIN);
    wait_for_state(S_CLEAR, 4, "b2b_wait_clear");
    model_rate = 128;
    clear_and_settle(model_rate, "b2b_final");

    // Disable mid-SETTLE.
    enable_i = 1'b0;
    wait_for_state(S_IDLE, 5, "dis_idle");
    check("dis_idle_en", cic_en_o, 1'b0);
    enable_i = 1'b1;
    tick();
    check("dis_clear", state_o, S_CLEAR);
    tick();
    model_beats = 0;
    send_beat("dis_beat");
    send_beat("dis_beat");
    check("dis_cnt2", settle_cnt_o, 8'd2);
    enable_i = 1'b0;
    tick();
    check("dis_state", state_o, S_IDLE);
    check("dis_cnt0", settle_cnt_o, 8'd0);
    check("dis_en", cic_en_o, 1'b0);

    // Reset in RUN with a pending rate and a stalled beat.
    enable_i = 1'b1;
    wait_for_state(S_CLEAR, 3, "rst_wait_clear");
    clear_and_settle(model_rate, "rst_pre");
    r = 16'($urandom_range(RATE_DEFAULT + 1, RATE_MAX));
    req_valid_i = 1'b1; req_rate_i = r;
    tvalid_s_in = 1'b1; tready_m_out = 1'b0;
    tick();
    req_valid_i = 1'b0;
    check("rst_pending", req_ready_o, 1'b0);
    check("rst_in_run", state_o, S_RUN);
    reset = 1'b1;
    tick();
    check_reset_values("midrst");
    reset = 1'b0;
    tvalid_s_in = 1'b0; tready_m_out = 1'b1;
    tick();
    check("midrst_clear", cic_clear_o, 1'b1);
    tick();
    check("midrst_rate_lost", cic_rate_o, RATE_DEFAULT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
